// File: rtl/prog_loader.sv
// Host-side boot loader: parses a header/count/payload word stream into
// instruction or data memory writes and sequences CPU enable/start/stop.
module prog_loader #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          i_we,
  output logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_data,
  output logic          d_we,
  output logic [AW-1:0] d_addr,
  output logic [DW-1:0] d_data,
  output logic          cpu_enable,
  output logic          cpu_start,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_ENA   = 3'd3;
  localparam logic [2:0] ST_START = 3'd4;
  localparam logic [2:0] ST_RUN   = 3'd5;

  localparam logic [1:0] OP_IMEM = 2'b00;
  localparam logic [1:0] OP_DMEM = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;

  logic [2:0]    state;
  logic          op_dmem;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   remaining;
  logic          i_we_q;
  logic          d_we_q;
  logic          cpu_enable_q;
  logic          cpu_start_q;
  logic          err_q;
  logic          state_accepts;
  logic          accept;
  logic [1:0]    hdr_op;
  logic          hdr_rsvd_bad;
  logic          cnt_bad;

  assign hdr_op       = in_data[DW-1:DW-2];
  assign hdr_rsvd_bad = |in_data[DW-3:AW];
  assign cnt_bad      = |in_data[DW-1:AW];

  assign state_accepts = (state == ST_IDLE) || (state == ST_COUNT) ||
                         (state == ST_LOAD) || (state == ST_RUN);

  // Strobes are masked during reset so a write pending in the reset cycle never lands.
  assign in_ready   = state_accepts & ~reset;
  assign accept     = in_valid & in_ready;
  assign i_we       = i_we_q & ~reset;
  assign d_we       = d_we_q & ~reset;
  assign cpu_enable = cpu_enable_q & ~reset;
  assign cpu_start  = cpu_start_q & ~reset;
  assign busy       = (state != ST_IDLE) & ~reset;
  assign err        = err_q;
  assign i_addr     = wr_addr;
  assign d_addr     = wr_addr;
  assign i_data     = wr_data;
  assign d_data     = wr_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_dmem      <= 1'b0;
      next_addr    <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      remaining    <= '0;
      i_we_q       <= 1'b0;
      d_we_q       <= 1'b0;
      cpu_enable_q <= 1'b0;
      cpu_start_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      i_we_q      <= 1'b0;
      d_we_q      <= 1'b0;
      cpu_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (hdr_rsvd_bad) begin
              err_q <= 1'b1;
            end else begin
              case (hdr_op)
                OP_IMEM, OP_DMEM: begin
                  op_dmem   <= (hdr_op == OP_DMEM);
                  next_addr <= in_data[AW-1:0];
                  state     <= ST_COUNT;
                end
                OP_RUN: begin
                  cpu_enable_q <= 1'b1;
                  state        <= ST_ENA;
                end
                default: ;
              endcase
            end
          end
        end
        ST_COUNT: begin
          if (accept) begin
            if (cnt_bad) begin
              err_q <= 1'b1;
              state <= ST_IDLE;
            end else begin
              remaining <= {1'b0, in_data[AW-1:0]} + CNT_ONE;
              state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wr_addr   <= next_addr;
            wr_data   <= in_data;
            i_we_q    <= ~op_dmem;
            d_we_q    <= op_dmem;
            next_addr <= next_addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_ENA: begin
          cpu_start_q <= 1'b1;
          state       <= ST_START;
        end
        ST_START: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            if (hdr_op == OP_STOP && !hdr_rsvd_bad) begin
              cpu_enable_q <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side boot block that sits directly upstream of the instruction/data memories and the pipelined CPU.
- Receives a 16-bit word stream over a valid/ready handshake and writes program words into instruction memory and operand words into data memory.
- Sequences the CPU enable and start controls so a program is loaded and launched without bench-level hierarchical writes.
- Also provides a stop command that returns the system to load mode.

Parameters:
- AW, 8, memory address width; matches the 8-bit CPU i_addr/d_addr.
- DW, 16, word width; matches the CPU instruction and data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  DW  host word: header, count or payload.
- i_we  out  1  instruction-memory write enable.
- i_addr  out  AW  instruction-memory write address.
- i_data  out  DW  instruction-memory write data.
- d_we  out  1  data-memory write enable.
- d_addr  out  AW  data-memory write address.
- d_data  out  DW  data-memory write data.
- cpu_enable  out  1  CPU enable; 0 while loading.
- cpu_start  out  1  single-cycle CPU start pulse.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Handshake: a word is accepted on a cycle where in_valid & in_ready are both high. in_data is sampled only on accept.
- Header format:
  - [15:14] op: 00 = load imem, 01 = load dmem, 10 = run, 11 = stop.
  - [13:8] must be 0.
  - [7:0] base address; ignored for run/stop.
- Count word: [7:0] = N-1, so N = 1..256 payload words follow. [15:8] must be 0.
- States: IDLE, COUNT, LOAD, ENA, START, RUN.
- IDLE (in_ready=1):
  - Load header → latch op and base, go to COUNT.
  - Run → ENA.
  - Stop → stay IDLE, no error.
  - Nonzero [13:8] → set err, stay IDLE.
- COUNT (in_ready=1):
  - Valid count → latch remaining = N, go to LOAD.
  - Nonzero [15:8] → set err, go to IDLE with no writes.
- LOAD (in_ready=1):
  - Each accepted word is written one cycle after accept: i_we or d_we (per op) high for exactly one cycle, with addr and data registered.
  - Address starts at base and increments by 1 per word, wrapping 255 → 0 modulo 2^AW.
  - After the Nth word is accepted → IDLE. The final write still occurs in the following cycle.
  - Back-to-back accepts give back-to-back write cycles.
  - i_we and d_we are never high together.
- ENA (in_ready=0): cpu_enable goes 1; one cycle later → START.
- START (in_ready=0): cpu_start=1 for exactly this cycle → RUN.
- RUN (in_ready=1):
  - cpu_enable holds 1.
  - Stop header → cpu_enable goes 0 on the next edge, go to IDLE.
  - Any other header → word consumed, err set, stay RUN, no memory writes.
- Outputs are registered and contain no combinational path from in_data; in_ready is a function of state only.
- Reset:
  - All outputs 0; err cleared; state IDLE; address and count cleared.
  - in_ready is 0 during the reset cycle and 1 in the cycle after.
  - Reset mid-LOAD abandons the frame: already-written words remain in memory, and a write pending for the reset cycle is suppressed.
  - Reset in RUN drops cpu_enable.
- err is cleared only by reset.

Test Plan:
- Load imem: words 0x0000, 0x0002, then 0x0801, 0x1002, 0x8000 → i_we pulses at i_addr 0x00, 0x01, 0x02 with data 0x0801, 0x1002, 0x8000; d_we stays 0; busy returns to 0.
- Load dmem with wrap: 0x40FE, 0x0002, then 0x00AB, 0x3C00, 0x1234 → d_we at d_addr 0xFE, 0xFF, 0x00 with those data; err=0.
- Launch: header 0x8000 from IDLE → cpu_enable=1 in the cycle after accept; cpu_start=1 for exactly the following cycle only; in_ready=0 during both cycles.
- Stop and illegal header in RUN: header 0x0000 → err=1, no writes, cpu_enable remains 1; then 0xC000 → cpu_enable=0 next cycle, state IDLE, err still 1.
- Protocol errors: header 0x0100 → err=1, stays IDLE. Count word 0x0105 after a valid load header → err=1, no writes, back to IDLE.
- Reset mid-load: 4-word frame, assert reset after the 2nd payload word is accepted → only the 1st word written; all outputs 0; next frame loads correctly from its own base.
- Backpressure: toggle in_valid with gaps during a 256-word imem frame → exactly 256 writes at addresses 0..255 in order.
